branch_unit_ras: RTL
====================

Name: branch_unit_ras

Overview:
- Registered, parametrised branch-resolution stage for KGP-RISC. Successor to the combinational branch unit.
- Resolves the 12 branch opcodes (48–59) against the ALU flags and produces the taken/target decision.
- Adds a hardware return-address stack (RAS) of configurable depth, plus a valid/ready handshake to the fetch/PC stage.
- Sits between decode/ALU-flag logic and the PC-update mux.

Parameters:
- PC_W, 12, program-counter width.
- DATA_W, 32, register/rs_val width.
- LABEL_W, 26, immediate label width.
- RAS_DEPTH, 4, RAS entries (power of two, ≥2).
- PC_INC, 4, return-address increment for call.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  branch request present.
- in_ready  out  1  stage can accept a request.
- opcode  in  6  instruction opcode.
- label  in  LABEL_W  absolute target label.
- rs_val  in  DATA_W  register value for br.
- carry_flag, z_flag, overflow_flag, sign_flag  in  1 each  ALU flags.
- pc  in  PC_W  PC of the branch instruction.
- ra_old  in  DATA_W  architectural ra register, used as pop fallback.
- flush  in  1  discard the registered result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- is_branch  out  1  taken.
- target_pc  out  PC_W  next PC when taken.
- ra_wr_en  out  1  write ra (call only).
- ra_wr_data  out  DATA_W  zero-extended pc+PC_INC.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_ovf  out  1  sticky: a push overwrote the oldest entry.
- ras_unf  out  1  sticky: a pop found the stack empty.

Behaviour:
- Opcode map:
  - 48 b: target = label.
  - 49 br: target = rs_val.
  - 50 bz: taken if z=1. 51 bnz: taken if z=0.
  - 52 bcy: taken if carry=1. 53 bncy: taken if carry=0.
  - 54 bs: taken if sign=1. 55 bns: taken if sign=0.
  - 56 bv: taken if overflow=1. 57 bnv: taken if overflow=0.
  - 58 call: always taken, target = label, pushes the return address.
  - 59 ret: always taken, pops the return address.
  - Any other opcode: is_branch=0, target_pc=pc+PC_INC, no stack effect.
- Width rules:
  - label and rs_val are truncated to PC_W LSBs.
  - pc+PC_INC wraps modulo 2^PC_W.
- Untaken conditional branch: target_pc = pc+PC_INC.
- Handshake:
  - One register stage; latency 1 cycle from accept to out_valid.
  - in_ready = !out_valid | out_ready.
  - A request is accepted when in_valid & in_ready; outputs load on accept.
  - Output holds stable while out_valid & !out_ready.
  - out_valid clears on out_ready without a new accept.
- RAS is a circular buffer with top pointer and count. It updates only on accept.
  - Call: write pc+PC_INC at top+1. If count==RAS_DEPTH, overwrite the oldest entry, keep count, set ras_ovf. Otherwise count+1. Assert ra_wr_en for that result.
  - Ret with count>0: target = top entry, count-1.
  - Ret with count==0: target = ra_old[PC_W-1:0], set ras_unf, count stays 0.
- Flush:
  - Clears out_valid the same cycle (registered).
  - Has priority over a simultaneous accept, which is dropped; in_ready is ignored that cycle.
  - RAS state is not rolled back.
- Reset (async assert, synchronous deassert at the clk edge):
  - All outputs 0, count 0, pointers 0, stickies 0.
  - RAS contents are don't-care.
  - Reset mid-handshake drops the pending result.

Optional Feature:
- BRANCH_STATS_EN defined:
  - Adds outputs taken_cnt and ret_hit_cnt (32-bit, wrapping).
  - taken_cnt increments per accepted taken branch.
  - ret_hit_cnt increments per ret served from a non-empty RAS.
  - Both reset to 0.
- Undefined: no counters and no ports.

Decomposition:
- Package kgp_branch_pkg holds:
  - opcode constants OP_B..OP_RET (48–59);
  - function is_cond_taken(opcode, flags);
  - function next_seq_pc.
- Sub-module ras_stack (parameters RAS_DEPTH, PC_W):
  - ports push, pop, push_data, top_data, count, ovf, unf.

Test Plan:
1. Conditional flag sweep: opcode 50 with z=1 and pc=4, label=36 → target 36, is_branch=1. Opcode 50 with z=0 → target 8, is_branch=0. Repeat for 51–57 with the matching flag.
2. br: opcode 49 with rs_val=0x0000_0024 → target 36. rs_val=0xFFFF_F024 → target 0x024 (truncated).
3. Call/ret nesting, RAS_DEPTH=4:
   - calls from pc 4, 20, 40 → ra_wr_data 8, 24, 44, ras_count=3;
   - three rets → targets 44, 24, 8, ras_count=0, no stickies.
4. Overflow/underflow:
   - 5 calls from pc 0, 4, 8, 12, 16 → ras_ovf=1;
   - rets yield 20, 16, 12, 8;
   - 5th ret with ra_old=100 → target 100, ras_unf=1.
5. Backpressure: hold out_ready=0 for 3 cycles → in_ready=0, outputs stable. Release → next request accepted, no loss or duplication. flush plus a simultaneous accept → out_valid=0 next cycle.
6. Reset mid-operation: assert rst low asynchronously between edges with out_valid=1 and count=2 → outputs 0 immediately. After release, ret with ra_old=12 → target 12, ras_unf=1.

Source files
------------

// File: rtl/kgp_branch_pkg.sv
// Shared opcode constants and decode helpers for the KGP-RISC branch stage.
package kgp_branch_pkg;

    localparam logic [5:0] OP_B    = 6'd48;
    localparam logic [5:0] OP_BR   = 6'd49;
    localparam logic [5:0] OP_BZ   = 6'd50;
    localparam logic [5:0] OP_BNZ  = 6'd51;
    localparam logic [5:0] OP_BCY  = 6'd52;
    localparam logic [5:0] OP_BNCY = 6'd53;
    localparam logic [5:0] OP_BS   = 6'd54;
    localparam logic [5:0] OP_BNS  = 6'd55;
    localparam logic [5:0] OP_BV   = 6'd56;
    localparam logic [5:0] OP_BNV  = 6'd57;
    localparam logic [5:0] OP_CALL = 6'd58;
    localparam logic [5:0] OP_RET  = 6'd59;

    typedef struct packed {
        logic carry;
        logic z;
        logic overflow;
        logic sign;
    } flags_t;

    // Only the eight flag-conditional opcodes can return 1.
    function automatic logic is_cond_taken(input logic [5:0] opcode, input flags_t flags);
        case (opcode)
            OP_BZ:   return flags.z;
            OP_BNZ:  return !flags.z;
            OP_BCY:  return flags.carry;
            OP_BNCY: return !flags.carry;
            OP_BS:   return flags.sign;
            OP_BNS:  return !flags.sign;
            OP_BV:   return flags.overflow;
            OP_BNV:  return !flags.overflow;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc, input logic [31:0] inc);
        return pc + inc;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
    parameter int RAS_DEPTH = 4,
    parameter int PC_W      = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [PC_W-1:0]              push_data,
    output logic [PC_W-1:0]              top_data,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         ovf,
    output logic                         unf
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] top_inc;
    logic             full;
    logic             empty;

    assign top_inc  = top + 1'b1;
    assign full     = (count == CNT_W'(RAS_DEPTH));
    assign empty    = (count == '0);
    assign top_data = mem[top];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (push) begin
            // Wrapping the pointer onto the oldest slot is what discards it.
            top <= top_inc;
            if (full) ovf   <= 1'b1;
            else      count <= count + 1'b1;
        end else if (pop) begin
            if (!empty) begin
                top   <= top - 1'b1;
                count <= count - 1'b1;
            end else begin
                unf <= 1'b1;
            end
        end
    end

    // Contents need no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[top_inc] <= push_data;
    end

endmodule

// File: rtl/branch_unit_ras.sv
// Registered branch-resolution stage with return-address stack and valid/ready handshake.
// Optional BRANCH_STATS_EN adds taken/ret-hit counters.
module branch_unit_ras
    import kgp_branch_pkg::*;
#(
    parameter int PC_W      = 12,
    parameter int DATA_W    = 32,
    parameter int LABEL_W   = 26,
    parameter int RAS_DEPTH = 4,
    parameter int PC_INC    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [5:0]                 opcode,
    input  logic [LABEL_W-1:0]         label,
    input  logic [DATA_W-1:0]          rs_val,
    input  logic                       carry_flag,
    input  logic                       z_flag,
    input  logic                       overflow_flag,
    input  logic                       sign_flag,
    input  logic [PC_W-1:0]            pc,
    input  logic [DATA_W-1:0]          ra_old,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       is_branch,
    output logic [PC_W-1:0]            target_pc,
    output logic                       ra_wr_en,
    output logic [DATA_W-1:0]          ra_wr_data,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_ovf,
`ifdef BRANCH_STATS_EN
    output logic [31:0]                taken_cnt,
    output logic [31:0]                ret_hit_cnt,
`endif
    output logic                       ras_unf
);
    logic            accept;
    logic            push;
    logic            pop;
    logic            nxt_taken;
    logic [PC_W-1:0] nxt_target;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] top_data;
    flags_t          flags;

    assign flags    = '{carry: carry_flag, z: z_flag, overflow: overflow_flag, sign: sign_flag};
    assign seq_pc   = PC_W'(next_seq_pc(32'(pc), 32'(PC_INC)));
    assign in_ready = !out_valid || out_ready;
    // A flush drops any request offered in the same cycle.
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        nxt_taken  = 1'b0;
        nxt_target = seq_pc;
        push       = 1'b0;
        pop        = 1'b0;
        case (opcode)
            OP_B: begin
                nxt_taken  = 1'b1;
                nxt_target = label[PC_W-1:0];
            end
            OP_BR: begin
                nxt_taken  = 1'b1;
                nxt_target = rs_val[PC_W-1:0];
            end
            OP_CALL: begin
                nxt_taken  = 1'b1;
                nxt_target = label[PC_W-1:0];
                push       = accept;
            end
            OP_RET: begin
                nxt_taken  = 1'b1;
                nxt_target = (ras_count != '0) ? top_data : ra_old[PC_W-1:0];
                pop        = accept;
            end
            default: begin
                if (is_cond_taken(opcode, flags)) begin
                    nxt_taken  = 1'b1;
                    nxt_target = label[PC_W-1:0];
                end
            end
        endcase
    end

    ras_stack #(.RAS_DEPTH(RAS_DEPTH), .PC_W(PC_W)) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (seq_pc),
        .top_data  (top_data),
        .count     (ras_count),
        .ovf       (ras_ovf),
        .unf       (ras_unf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            is_branch  <= 1'b0;
            target_pc  <= '0;
            ra_wr_en   <= 1'b0;
            ra_wr_data <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            is_branch  <= nxt_taken;
            target_pc  <= nxt_target;
            ra_wr_en   <= (opcode == OP_CALL);
            ra_wr_data <= DATA_W'(seq_pc);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taken_cnt   <= '0;
            ret_hit_cnt <= '0;
        end else begin
            if (accept && nxt_taken)        taken_cnt   <= taken_cnt + 1'b1;
            if (pop && (ras_count != '0))   ret_hit_cnt <= ret_hit_cnt + 1'b1;
        end
    end
`endif

endmodule
